sramlike_arb2: RTL
==================

# sramlike_arb2

Two-master arbiter placed directly downstream of the load/store protocol converter's SRAM-like data port and the instruction-fetch converter's SRAM-like port. It merges them onto the single SRAM-like memory port of the core. Requests are granted round-robin and held until accepted. An in-order owner queue routes each `data_ok` response back to the master that issued it.

## Interface
Parameters:
- `OUTSTANDING`, default 2: maximum accepted-but-unanswered requests (owner queue depth, ≥1).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` in 1: the single clock.
  - `rst` in 1: synchronous, active-high reset.
- Instruction-side slave port, `i_`*:
  - `i_req` in 1
  - `i_addr` in 32
  - `i_ben` in 4
  - `i_wr` in 1
  - `i_din` in 32
  - `i_addr_ok` out 1
  - `i_data_ok` out 1
  - `i_dout` out 32
- Data-side slave port, `d_`*: same signals and widths as the `i_`* port.
- Memory master port:
  - `mem_req` out 1
  - `mem_addr` out 32
  - `mem_ben` out 4
  - `mem_wr` out 1
  - `mem_din` out 32
  - `mem_addr_ok` in 1
  - `mem_data_ok` in 1
  - `mem_dout` in 32
- `err_unexp` out 1: sticky flag, set on a `mem_data_ok` while the owner queue is empty.

## Operation
- SRAM-like rule on every port:
  - A request is live while `req`=1.
  - Its payload (`addr`, `ben`, `wr`, `din`) is stable until `addr_ok`.
  - Transfer occurs on the cycle `req & addr_ok`.
  - Responses come back strictly in request order, one per `data_ok`. Writes also get a `data_ok`, with don't-care `dout`.
- Grant FSM, states `IDLE`, `LOCK_I`, `LOCK_D`:
  - In `IDLE`, the grant is combinational:
    - If only one master requests, it wins.
    - If both request, the winner is the master not served last. The `last` register resets to I, so D wins the first tie.
  - `mem_req` = granted `req` & !`q_full`. The payload mux follows the grant.
  - If `mem_req`=1 and `mem_addr_ok`=0: go to `LOCK_<winner>`. The grant is frozen until `mem_addr_ok`, even if the other master requests.
  - On `mem_req & mem_addr_ok`:
    - Push the owner (0=I, 1=D) into the queue.
    - Update `last`.
    - Return to `IDLE`.
  - In `LOCK_x`, `mem_req` = `x_req` & !`q_full`. Upstream never withdraws a live request, so `x_req` stays 1.
- Accept routing: the winner's `addr_ok` = `mem_addr_ok` & `mem_req`. The loser's `addr_ok` = 0.
- Owner queue:
  - Circular buffer of `OUTSTANDING` 1-bit entries.
  - Read/write pointers of width `clog2(OUTSTANDING)`, wrapping modulo `OUTSTANDING`.
  - Count width is `clog2(OUTSTANDING+1)`.
  - `q_full` = count==`OUTSTANDING`.
- Response routing:
  - On `mem_data_ok` with a non-empty queue: `<head owner>_data_ok`=1, pop.
  - `i_dout` = `d_dout` = `mem_dout` unconditionally.
  - On `mem_data_ok` with an empty queue: no `data_ok` is raised and `err_unexp` is set. It is cleared only by `rst`.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Full queue: no grant is issued that cycle, even if a pop happens the same cycle. `mem_req` must not depend combinationally on `mem_data_ok`.

## Timing
- Reset values:
  - State `IDLE`, `last`=I, pointers and count 0, `err_unexp`=0.
  - All outputs are 0 except the payload muxes, which output I-side values.
- Zero-cycle request path: slave `req` to `mem_req` is combinational, and `mem_addr_ok` to slave `addr_ok` is combinational.
- Zero-cycle response path: `mem_data_ok` to slave `data_ok` is combinational. The queue head is registered.
- Back-to-back grants: a new grant is possible the cycle after an accept. Peak throughput is 1 request per cycle while not full.
- `rst` mid-transaction drops all queue contents and locks. The memory side is reset on the same `rst`, so no stale `data_ok` is expected afterwards.

## Structure
- Shared package `sramlike_pkg`:
  - Owner encoding constants `OWN_I`=0, `OWN_D`=1.
  - FSM state encoding `ARB_IDLE`/`ARB_LOCK_I`/`ARB_LOCK_D`, 2 bits.
- Sub-module `owner_fifo`:
  - Parameter `DEPTH`, 1-bit data.
  - Signals `push`, `pop`, `din`, `dout`, `full`, `empty`.
  - Synchronous active-high reset.
- The top level holds the FSM, `last`, the muxes and the error flag.

## Test plan
- Single D read:
  - Stimulus: `d_req`=1, `d_addr`=0x8000_0010, `mem_addr_ok`=1 in cycle 0; `mem_data_ok`=1 with `mem_dout`=0xDEADBEEF in cycle 2.
  - Response: `d_addr_ok`=1 in cycle 0; `d_data_ok`=1 with `d_dout`=0xDEADBEEF in cycle 2; `i_data_ok` stays 0.
- Tie and round-robin:
  - Stimulus: both masters request every cycle, `mem_addr_ok`=1.
  - Response: grants go D, I, D, I. The response order of `data_ok` matches the grant order.
- Lock:
  - Stimulus: I requests alone with `mem_addr_ok`=0 for 3 cycles; D requests from cycle 1.
  - Response: `mem_addr` stays at the I address until accept; D is granted the next cycle.
- Full queue:
  - Stimulus: with `OUTSTANDING`=2, issue 2 accepted requests with no response.
  - Response: the 3rd request sees `mem_req`=0. Then `mem_data_ok`=1, and the following cycle `mem_req`=1.
- Unexpected response:
  - Stimulus: `mem_data_ok`=1 with the queue empty.
  - Response: no slave `data_ok`; `err_unexp`=1 until `rst`.
- Reset mid-flight:
  - Stimulus: assert `rst` with 2 entries outstanding and the FSM in `LOCK_D`.
  - Response: the next cycle shows `IDLE`, queue empty, all outputs at reset values.

Source files
------------

// File: rtl/sramlike_pkg.sv
// Shared definitions for the two-master SRAM-like arbiter: owner encoding
// and grant FSM state encoding.
package sramlike_pkg;

  // Owner tag stored in the response-routing queue.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Grant FSM: IDLE picks a winner combinationally; LOCK_x freezes the
  // grant on master x while its request waits for mem_addr_ok.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_t;

  // Lock state that freezes the grant on a given owner.
  function automatic arb_state_t lock_of(input logic owner);
    return (owner == OWN_D) ? ARB_LOCK_D : ARB_LOCK_I;
  endfunction

endpackage

// File: rtl/owner_fifo.sv
// In-order queue of 1-bit owner tags, one entry per accepted request that is
// still waiting for its data_ok. Head is read straight from registers.
module owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; push and pop may happen together.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sramlike_arb2.sv
// Round-robin arbiter merging the instruction-fetch and load/store SRAM-like
// ports onto one memory port. Responses are steered back in order through
// an owner queue.
//
// Handshake: on every port a request is live while req=1, its payload is
// held stable until addr_ok, and the transfer happens on the cycle where
// req & addr_ok. Each transfer gets exactly one data_ok later, in request
// order (writes included; dout is don't-care for writes).
module sramlike_arb2
  import sramlike_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-side slave port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_ben,
  input  logic        i_wr,
  input  logic [31:0] i_din,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_dout,
  // data-side slave port
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_ben,
  input  logic        d_wr,
  input  logic [31:0] d_din,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_dout,
  // memory master port
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_ben,
  output logic        mem_wr,
  output logic [31:0] mem_din,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_dout,
  // status
  output logic        err_unexp,
  output arb_state_t  dbg_state
);

  arb_state_t state;
  arb_state_t state_nxt;
  logic       last;
  logic       win;
  logic       win_req;
  logic       accept;
  logic       q_full;
  logic       q_empty;
  logic       q_head;
  logic       pop;

  assign dbg_state = state;

  // Winner selection: frozen while locked, otherwise single requester wins
  // and a tie goes to the master not served last. I is the idle default so
  // the payload mux shows I-side values when nobody requests.
  always_comb begin
    win = OWN_I;
    case (state)
      ARB_LOCK_I: win = OWN_I;
      ARB_LOCK_D: win = OWN_D;
      default: begin
        if (i_req && d_req) begin
          win = (last == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
          win = OWN_D;
        end else begin
          win = OWN_I;
        end
      end
    endcase
  end

  // Request and payload muxing. A full queue blocks the grant regardless
  // of any same-cycle pop, so mem_req never depends on mem_data_ok.
  assign win_req   = (win == OWN_D) ? d_req : i_req;
  assign mem_req   = win_req & ~q_full;
  assign mem_addr  = (win == OWN_D) ? d_addr : i_addr;
  assign mem_ben   = (win == OWN_D) ? d_ben  : i_ben;
  assign mem_wr    = (win == OWN_D) ? d_wr   : i_wr;
  assign mem_din   = (win == OWN_D) ? d_din  : i_din;
  assign accept    = mem_req & mem_addr_ok;
  assign i_addr_ok = accept & (win == OWN_I);
  assign d_addr_ok = accept & (win == OWN_D);

  // Next-state logic for the grant FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (mem_req && !mem_addr_ok) begin
          state_nxt = lock_of(win);
        end
      end
      ARB_LOCK_I, ARB_LOCK_D: begin
        if (accept) begin
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // FSM state and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      last  <= OWN_I;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last <= win;
      end
    end
  end

  // Response steering: the head owner gets the data_ok; read data fans out
  // to both masters unconditionally.
  assign pop       = mem_data_ok & ~q_empty;
  assign i_data_ok = pop & (q_head == OWN_I);
  assign d_data_ok = pop & (q_head == OWN_D);
  assign i_dout    = mem_dout;
  assign d_dout    = mem_dout;

  // Sticky flag for a response that nothing was waiting for.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_unexp <= 1'b0;
    end else if (mem_data_ok && q_empty) begin
      err_unexp <= 1'b1;
    end
  end

  owner_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (win),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule
